// File: rtl/invkey_pkg.sv
// Shared types and helpers for the inverse AES-128 key schedule.
// Byte k of a 128-bit key sits at bits [8k+7:8k]; word j at [32j+31:32j].
package invkey_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic word_t key_word(input logic [127:0] k, input logic [1:0] j);
    return k[{j, 5'b00000} +: 32];
  endfunction

  function automatic logic [7:0] word_byte(input word_t w, input logic [1:0] j);
    return w[{j, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/invkey_if.sv
// Request/result bundle between a requester and the inverse key schedule.
interface invkey_if;
  logic         start;
  logic [127:0] in;
  logic [3:0]   round;
  logic [3:0]   steps;
  logic         finish;
  logic [127:0] prevkey;
  logic         err;

  modport master (output start, in, round, steps, input finish, prevkey, err);
  modport slave  (input start, in, round, steps, output finish, prevkey, err);
endinterface

// File: rtl/invkey_sbox.sv
// Combinational AES forward S-box; table stored MSB-first, entry 0 in the top byte.
module invkey_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 255-a == ~a for an 8-bit index, so entry a starts at bit 8*(~a).
  assign y_o = SBOX_FLAT[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/invkey.sv
// Inverse AES-128 key schedule: walks a round key back 'steps' rounds,
// five cycles per round using a single time-shared S-box.
module invkey
  import invkey_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input logic      clk,
  input logic      rst,
  invkey_if.slave  bus
);

  state_e       state_q;
  logic [2:0]   b_q;
  logic [3:0]   rnd_q;
  logic [3:0]   rem_q;
  logic [127:0] key_q;
  word_t        temp_q;
  logic         finish_q;
  logic [127:0] prevkey_q;
  logic         err_q;

  word_t        w3_new, w2_new, w1_new, w0_new;
  logic [127:0] key_d;
  logic [7:0]   sbox_a, sbox_y;
  logic         bad_req;

  assign w3_new = key_word(key_q, 2'd3) ^ key_word(key_q, 2'd2);
  assign w2_new = key_word(key_q, 2'd2) ^ key_word(key_q, 2'd1);
  assign w1_new = key_word(key_q, 2'd1) ^ key_word(key_q, 2'd0);
  // temp_q already holds SubWord(RotWord(w3_new)) once b reaches 4.
  assign w0_new = key_word(key_q, 2'd0) ^ temp_q ^ {24'h0, rcon(rnd_q)};
  assign key_d  = {w3_new, w2_new, w1_new, w0_new};

  assign sbox_a = word_byte(w3_new, b_q[1:0] + 2'd1);

  invkey_sbox u_sbox (
    .a_i (sbox_a),
    .y_o (sbox_y)
  );

  assign bad_req = (bus.round == 4'd0) || (bus.round > 4'(NR)) || (bus.steps > bus.round);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      b_q       <= '0;
      rnd_q     <= '0;
      rem_q     <= '0;
      key_q     <= '0;
      temp_q    <= '0;
      finish_q  <= 1'b0;
      prevkey_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            key_q <= bus.in;
            rnd_q <= bus.round;
            rem_q <= bus.steps;
            b_q   <= '0;
            if (bad_req || bus.steps == 4'd0) begin
              state_q   <= DONE;
              finish_q  <= 1'b1;
              err_q     <= bad_req;
              prevkey_q <= bus.in;
            end else begin
              state_q <= STEP;
            end
          end
        end
        STEP: begin
          if (!bus.start) begin
            state_q <= IDLE;
            b_q     <= '0;
          end else if (b_q != 3'd4) begin
            temp_q[{b_q[1:0], 3'b000} +: 8] <= sbox_y;
            b_q <= b_q + 3'd1;
          end else begin
            key_q <= key_d;
            rnd_q <= rnd_q - 4'd1;
            rem_q <= rem_q - 4'd1;
            b_q   <= '0;
            if (rem_q == 4'd1) begin
              state_q   <= DONE;
              finish_q  <= 1'b1;
              err_q     <= 1'b0;
              prevkey_q <= key_d;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            state_q  <= IDLE;
            finish_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.finish  = finish_q;
  assign bus.prevkey = prevkey_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_invkey.sv
// Randomized and directed checks of invkey against a GF(2^8)-derived reference model.
module tb_invkey;

  logic clk = 1'b0;
  logic rst;
  invkey_if bus ();

  invkey dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  logic [7:0] sb [256];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S(x) = affine(x^-1), with x^-1 = x^254 (0 maps to 0)
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int r);
    logic [7:0] rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    return rc;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] n [4];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
    n[3] = w[3] ^ w[2];
    n[2] = w[2] ^ w[1];
    n[1] = w[1] ^ w[0];
    for (int j = 0; j < 4; j++) t[8*j +: 8] = sb[n[3][8*((j+1)%4) +: 8]];
    n[0] = w[0] ^ t ^ {24'h0, rcon_ref(r)};
    return {n[3], n[2], n[1], n[0]};
  endfunction

  function automatic logic [127:0] walk_back(input logic [127:0] k, input int r, input int s);
    logic [127:0] key = k;
    for (int i = 0; i < s; i++) key = inv_round(key, r - i);
    return key;
  endfunction

  task automatic run_req(input string tag, input logic [127:0] k, input logic [3:0] r,
                         input logic [3:0] s, input bit scramble);
    bit          illegal;
    int          exp_lat, lat;
    logic [127:0] exp_key;
    illegal = (r == 0) || (r > 10) || (s > r);
    exp_lat = (illegal || s == 0) ? 0 : 5 * int'(s);
    exp_key = illegal ? k : walk_back(k, int'(r), int'(s));
    @(negedge clk);
    bus.in = k; bus.round = r; bus.steps = s; bus.start = 1'b1;
    @(negedge clk);
    if (scramble) begin
      bus.in    = {$urandom, $urandom, $urandom, $urandom};
      bus.round = 4'($urandom);
      bus.steps = 4'($urandom);
    end
    lat = 0;
    while (!bus.finish && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_key"}, bus.prevkey, exp_key);
    chk({tag, "_err"}, 128'(bus.err), 128'(illegal));
    @(negedge clk);
    chk({tag, "_hold"}, 128'(bus.finish), 128'(1));
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, 128'(bus.finish), 128'(0));
  endtask

  localparam logic [127:0] K1   = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] K10  = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] KCIP = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

  initial begin
    logic [127:0] saved, rk;
    bit           seen;
    logic [3:0]   r, s;
    for (int a = 0; a < 256; a++) sb[a] = sbox_ref(8'(a));

    rst = 1'b1;
    bus.start = 1'b0; bus.in = '0; bus.round = '0; bus.steps = '0;
    repeat (2) @(negedge clk);
    chk("rst_fin", 128'(bus.finish), 128'(0));
    chk("rst_key", bus.prevkey, 128'(0));
    chk("rst_err", 128'(bus.err), 128'(0));
    rst = 1'b0;

    // Published FIPS-197 vectors pin the model as well as the DUT.
    chk("model_1", walk_back(K1, 1, 1), KCIP);
    chk("model_10", walk_back(K10, 10, 10), KCIP);

    run_req("single", K1, 4'd1, 4'd1, 1'b0);
    run_req("full", K10, 4'd10, 4'd10, 1'b1);
    run_req("zero", 128'h0123456789abcdeffedcba9876543210, 4'd5, 4'd0, 1'b0);
    run_req("ill_a", 128'h11112222333344445555666677778888, 4'd3, 4'd4, 1'b0);
    run_req("ill_b", 128'h99990000aaaabbbbccccddddeeeeffff, 4'd0, 4'd0, 1'b0);
    run_req("ill_c", 128'hdeadbeefcafef00d0badf00d12345678, 4'd11, 4'd1, 1'b0);

    // Abort a long walk after seven edges, then restart.
    saved = bus.prevkey;
    @(negedge clk);
    bus.in = K10; bus.round = 4'd10; bus.steps = 4'd10; bus.start = 1'b1;
    @(negedge clk);
    repeat (6) @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.finish) seen = 1'b1;
    end
    chk("abort_fin", 128'(seen), 128'(0));
    chk("abort_key", bus.prevkey, saved);
    run_req("restart", K1, 4'd1, 4'd1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      r  = 4'($urandom_range(0, 15));
      s  = 4'($urandom_range(0, (r < 15) ? int'(r) + 1 : 15));
      run_req("rand", rk, r, s, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
